// File: rtl/sort_pkg.sv
// sort_pkg: shared helpers for the wide_sort_pipe odd-even transposition sorter.
//   clog2 - ceiling log2 with a floor of 1, so single-value fields
//           still get one bit.
package sort_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/sort_cmp_swap.sv
// sort_cmp_swap: one compare-exchange cell, purely combinational.
// Lanes are packed {key, tag, idx} with the key in the top N bits.
//   i_lo, i_hi : lanes at positions i and i+1
//   i_desc     : 0 = ascending, 1 = descending
//   o_lo, o_hi : ordered lanes
// Equal keys never swap, which keeps the whole network stable.
module sort_cmp_swap #(
  parameter int N = 4,
  parameter int W = 12
) (
  input  logic [W-1:0] i_lo,
  input  logic [W-1:0] i_hi,
  input  logic         i_desc,
  output logic [W-1:0] o_lo,
  output logic [W-1:0] o_hi
);

  logic [N-1:0] w_klo, w_khi;
  logic         w_swap;

  assign w_klo  = i_lo[W-1 -: N];
  assign w_khi  = i_hi[W-1 -: N];
  assign w_swap = i_desc ? (w_klo < w_khi) : (w_klo > w_khi);
  assign o_lo   = w_swap ? i_hi : i_lo;
  assign o_hi   = w_swap ? i_lo : i_hi;

endmodule

// File: rtl/wide_sort_pipe.sv
// wide_sort_pipe: M-stage pipelined odd-even transposition sorter.
//   Clk, Reset          : clock, async active-high reset
//   InValid/InReady     : input handshake; X, XTag, InDesc sampled on accept
//   OutValid/OutReady   : output handshake; Y, YTag, YIdx, YDesc from last stage
//   Count               : vectors currently in flight (0..M)
// Stage s compare-exchanges pairs (i,i+1) with i%2 == s%2, then registers.
// A single global enable stalls every stage together, so occupancy
// can never exceed M.
module wide_sort_pipe
  import sort_pkg::*;
#(
  parameter int N = 4,
  parameter int M = 4,
  parameter int T = 4
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  InValid,
  output logic                  InReady,
  input  logic                  InDesc,
  input  logic [N-1:0]          X     [M],
  input  logic [T-1:0]          XTag  [M],
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic [N-1:0]          Y     [M],
  output logic [T-1:0]          YTag  [M],
  output logic [clog2(M)-1:0]   YIdx  [M],
  output logic                  YDesc,
  output logic [clog2(M+1)-1:0] Count
);

  localparam int IW = clog2(M);
  localparam int CW = clog2(M+1);
  localparam int LW = N + T + IW;

  typedef struct packed {
    logic [N-1:0]  key;
    logic [T-1:0]  tag;
    logic [IW-1:0] idx;
  } lane_t;

  logic          w_adv, w_acc, w_dec;
  lane_t         w_src [M][M];   // stage s input lanes
  lane_t         w_nxt [M][M];   // stage s output lanes, pre-register
  logic          w_dsrc [M];
  lane_t         r_lane [M][M];
  logic [M-1:0]  r_vld_pipe;
  logic [M-1:0]  r_desc;
  logic [CW-1:0] r_cnt;

  assign w_adv   = ~r_vld_pipe[M-1] | OutReady;
  assign InReady = w_adv & ~Reset;
  assign w_acc   = InValid & InReady;
  assign w_dec   = r_vld_pipe[M-1] & OutReady;

  for (genvar s = 0; s < M; s++) begin : g_stage
    if (s == 0) begin : g_in
      assign w_dsrc[s] = InDesc;
    end else begin : g_prev
      assign w_dsrc[s] = r_desc[s-1];
    end
    for (genvar i = 0; i < M; i++) begin : g_lane
      if (s == 0) begin : g_ld
        assign w_src[s][i] = lane_t'{X[i], XTag[i], IW'(i)};
      end else begin : g_fw
        assign w_src[s][i] = r_lane[s-1][i];
      end
      if (((i % 2) == (s % 2)) && (i + 1 < M)) begin : g_pair
        sort_cmp_swap #(.N(N), .W(LW)) u_cs (
          .i_lo   (w_src[s][i]),
          .i_hi   (w_src[s][i+1]),
          .i_desc (w_dsrc[s]),
          .o_lo   (w_nxt[s][i]),
          .o_hi   (w_nxt[s][i+1])
        );
      end else if (!((i > 0) && (((i - 1) % 2) == (s % 2)))) begin : g_pass
        // edge lane with no partner this stage
        assign w_nxt[s][i] = w_src[s][i];
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_vld_pipe <= '0;
      r_desc     <= '0;
      for (int s = 0; s < M; s++)
        for (int i = 0; i < M; i++)
          r_lane[s][i] <= '0;
    end else if (w_adv) begin
      r_vld_pipe <= {r_vld_pipe[M-2:0], w_acc};
      r_desc     <= {r_desc[M-2:0], InDesc};
      for (int s = 0; s < M; s++)
        for (int i = 0; i < M; i++)
          r_lane[s][i] <= w_nxt[s][i];
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_cnt <= '0;
    end else begin
      case ({w_acc, w_dec})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  for (genvar i = 0; i < M; i++) begin : g_out
    assign Y[i]    = r_lane[M-1][i].key;
    assign YTag[i] = r_lane[M-1][i].tag;
    assign YIdx[i] = r_lane[M-1][i].idx;
  end
  assign OutValid = r_vld_pipe[M-1];
  assign YDesc    = r_desc[M-1];
  assign Count    = r_cnt;

endmodule

// File: tb/tb_wide_sort_pipe.sv
// tb_wide_sort_pipe: scoreboard bench for wide_sort_pipe (N=4, M=4, T=4).
// Stimulus pushes hand-computed expected vectors on accept; a negedge
// monitor pops and compares on every output handshake.
module tb_wide_sort_pipe;
  localparam int N = 4, M = 4, T = 4;

  logic         Clk = 0, Reset = 1, InValid = 0, InDesc = 0, OutReady = 0;
  logic [N-1:0] X [M];
  logic [T-1:0] XTag [M];
  logic         InReady, OutValid, YDesc;
  logic [N-1:0] Y [M];
  logic [T-1:0] YTag [M];
  logic [1:0]   YIdx [M];
  logic [2:0]   Count;

  wide_sort_pipe #(.N(N), .M(M), .T(T)) dut (
    .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .InDesc(InDesc), .X(X), .XTag(XTag), .OutValid(OutValid),
    .OutReady(OutReady), .Y(Y), .YTag(YTag), .YIdx(YIdx), .YDesc(YDesc),
    .Count(Count)
  );

  always #5 Clk = ~Clk;

  int checks = 0, failures = 0;

  typedef struct packed {
    logic [15:0] y;
    logic [15:0] tag;
    logic [7:0]  idx;
    logic        desc;
  } exp_t;
  exp_t q[$];
  exp_t m_e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  function automatic logic [15:0] v4(input int a, input int b, input int c, input int d);
    return {d[3:0], c[3:0], b[3:0], a[3:0]};
  endfunction

  function automatic logic [7:0] i4(input int a, input int b, input int c, input int d);
    return {d[1:0], c[1:0], b[1:0], a[1:0]};
  endfunction

  function automatic logic [15:0] ypk();
    return {Y[3], Y[2], Y[1], Y[0]};
  endfunction

  function automatic logic [15:0] tpk();
    return {YTag[3], YTag[2], YTag[1], YTag[0]};
  endfunction

  function automatic logic [7:0] ipk();
    return {YIdx[3], YIdx[2], YIdx[1], YIdx[0]};
  endfunction

  // monitor: handshake completes at the next rising edge
  always @(negedge Clk) begin
    if (!Reset && OutValid && OutReady) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got Y=%h with empty scoreboard", ypk());
      end else begin
        m_e = q.pop_front();
        chk("out_y",    32'(ypk()),  32'(m_e.y));
        chk("out_tag",  32'(tpk()),  32'(m_e.tag));
        chk("out_idx",  32'(ipk()),  32'(m_e.idx));
        chk("out_desc", 32'(YDesc),  32'(m_e.desc));
      end
    end
  end

  // Present one vector and wait (bounded) for acceptance; returns 1ns after the accepting edge.
  task automatic send(input logic [15:0] x, input logic [15:0] tg, input logic d,
                      input logic [15:0] ey, input logic [7:0] ei);
    exp_t e;
    bit   acc;
    acc = 0;
    for (int j = 0; j < M; j++) begin
      X[j]    = x[4*j +: 4];
      XTag[j] = tg[4*j +: 4];
    end
    InDesc  = d;
    InValid = 1;
    e.y    = ey;
    e.idx  = ei;
    e.desc = d;
    for (int j = 0; j < M; j++) e.tag[4*j +: 4] = tg[4*int'(ei[2*j +: 2]) +: 4];
    for (int k = 0; k < 16 && !acc; k++) begin
      @(negedge Clk);
      acc = InReady;
      @(posedge Clk);
      #1;
    end
    InValid = 0;
    if (acc) q.push_back(e);
    else begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got no accept expected accept within 16 cycles");
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  logic [15:0] snap_y, snap_t;
  logic [15:0] TG;

  initial begin
    TG = v4(4'hA, 4'hB, 4'hC, 4'hD);
    for (int j = 0; j < M; j++) begin
      X[j] = '0;
      XTag[j] = '0;
    end
    #3;
    chk("reset_outvalid", 32'(OutValid), 0);
    chk("reset_count",    32'(Count),    0);
    chk("reset_inready",  32'(InReady),  0);
    chk("reset_y",        32'(ypk()),    0);
    @(posedge Clk);
    #2 Reset = 0;
    cyc(1);
    chk("inready_after_reset", 32'(InReady), 1);
    OutReady = 1;

    // ascending with latency check
    send(v4(9,3,12,3), TG, 0, v4(3,3,9,12), i4(1,3,0,2));
    cyc(1); chk("lat_asc_k1", 32'(OutValid), 0);
    cyc(1); chk("lat_asc_k2", 32'(OutValid), 0);
    cyc(1); chk("lat_asc_k3", 32'(OutValid), 1);
    chk("lat_asc_count", 32'(Count), 1);
    cyc(3);

    // descending with ties
    send(v4(9,3,12,3), TG, 1, v4(12,9,3,3), i4(2,0,1,3));
    cyc(5);

    // streaming, alternating direction
    send(v4(15,0,15,0), v4(1,2,3,4), 0, v4(0,0,15,15), i4(1,3,0,2));
    send(v4(0,0,0,0),   v4(5,6,7,8), 1, v4(0,0,0,0),   i4(0,1,2,3));
    send(v4(7,6,5,4),   v4(9,8,7,6), 0, v4(4,5,6,7),   i4(3,2,1,0));
    send(v4(1,2,3,4),   v4(3,1,4,1), 1, v4(4,3,2,1),   i4(3,2,1,0));
    chk("stream_count_a", 32'(Count), 4);
    send(v4(2,8,2,8),   v4(2,7,1,8), 0, v4(2,2,8,8),   i4(0,2,1,3));
    chk("stream_count_b", 32'(Count), 4);
    send(v4(15,0,15,0), v4(6,5,4,3), 1, v4(15,15,0,0), i4(0,2,1,3));
    chk("stream_count_c", 32'(Count), 4);
    cyc(8);
    chk("stream_drained", 32'(Count), 0);
    chk("stream_q_empty", 32'(q.size()), 0);

    // backpressure
    OutReady = 0;
    send(v4(9,3,12,3), TG,          0, v4(3,3,9,12),  i4(1,3,0,2));
    send(v4(9,3,12,3), TG,          1, v4(12,9,3,3),  i4(2,0,1,3));
    send(v4(5,1,4,2),  v4(1,2,3,4), 0, v4(1,2,4,5),   i4(1,3,2,0));
    send(v4(7,6,5,4),  v4(4,3,2,1), 1, v4(7,6,5,4),   i4(0,1,2,3));
    chk("bp_count_full", 32'(Count),    4);
    chk("bp_outvalid",   32'(OutValid), 1);
    snap_y = v4(3,3,9,12);
    snap_t = v4(4'hB, 4'hD, 4'hA, 4'hC);
    for (int c = 0; c < 5; c++) begin
      cyc(1);
      chk("bp_count",   32'(Count),   4);
      chk("bp_inready", 32'(InReady), 0);
      chk("bp_y_hold",  32'(ypk()),   32'(snap_y));
      chk("bp_tag_hold", 32'(tpk()),  32'(snap_t));
    end
    OutReady = 1;
    cyc(8);
    chk("bp_drained", 32'(Count),    0);
    chk("bp_q_empty", 32'(q.size()), 0);

    // bubbles
    send(v4(2,8,2,8), v4(2,7,1,8), 1, v4(8,8,2,2), i4(1,3,0,2));
    chk("bub_count_1", 32'(Count), 1);
    cyc(1);
    chk("bub_count_2", 32'(Count), 1);
    send(v4(5,1,4,2), v4(1,2,3,4), 1, v4(5,4,2,1), i4(0,2,3,1));
    chk("bub_count_3", 32'(Count), 2);
    cyc(1); chk("bub_out_a",   32'(OutValid), 1);
    cyc(1); chk("bub_out_gap", 32'(OutValid), 0);
    cyc(1); chk("bub_out_b",   32'(OutValid), 1);
    cyc(4);
    chk("bub_q_empty", 32'(q.size()), 0);

    // reset mid-stream
    send(v4(9,3,12,3), TG, 0, v4(3,3,9,12), i4(1,3,0,2));
    send(v4(7,6,5,4),  TG, 0, v4(4,5,6,7),  i4(3,2,1,0));
    send(v4(1,2,3,4),  TG, 1, v4(4,3,2,1),  i4(3,2,1,0));
    chk("rst_count_pre", 32'(Count), 3);
    #2 Reset = 1;
    #1;
    chk("rst_outvalid", 32'(OutValid), 0);
    chk("rst_count",    32'(Count),    0);
    chk("rst_y",        32'(ypk()),    0);
    chk("rst_idx",      32'(ipk()),    0);
    chk("rst_desc",     32'(YDesc),    0);
    chk("rst_inready",  32'(InReady),  0);
    q.delete();
    @(posedge Clk);
    @(negedge Clk);
    Reset = 0;
    cyc(1);
    chk("rst_inready_after", 32'(InReady), 1);
    send(v4(5,1,4,2), v4(1,2,3,4), 0, v4(1,2,4,5), i4(1,3,2,0));
    cyc(1); chk("rst_lat_k1", 32'(OutValid), 0);
    cyc(1); chk("rst_lat_k2", 32'(OutValid), 0);
    cyc(1); chk("rst_lat_k3", 32'(OutValid), 1);
    cyc(5);
    chk("final_q_empty", 32'(q.size()), 0);
    chk("final_count",   32'(Count),    0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
